// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: operand forwarding plus scoreboard hazard detection
// between decode and execute, with a saturating stall-cycle counter.
module forward_hazard_unit #(
  parameter int ADDR_W = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int CNT_W = 3,
  parameter int STALL_CNT_W = 16,
  localparam int SEL_W = $clog2(NUM_FWD + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_rd,
  input  logic [CNT_W-1:0]           issue_lat,
  input  logic [NUM_SRC*ADDR_W-1:0]  src_addr,
  input  logic [NUM_SRC-1:0]         src_used,
  input  logic                       flush,
  input  logic [NUM_FWD-1:0]         fwd_valid,
  input  logic [NUM_FWD*ADDR_W-1:0]  fwd_rd,
  output logic                       stall,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic [STALL_CNT_W-1:0]     stall_cycles
);

  localparam int NREG = 1 << ADDR_W;

  logic [CNT_W-1:0] pend [NREG];
  logic rawHaz;
  logic wawHaz;
  logic issueFire;
  logic loadPend;

  always_comb begin
    logic [ADDR_W-1:0] a;
    rawHaz = 1'b0;
    a = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      a = src_addr[i*ADDR_W +: ADDR_W];
      if (src_used[i] && a != '0 && pend[a] != '0)
        rawHaz = 1'b1;
    end
  end

  assign wawHaz = issue_valid && issue_rd != '0
               && pend[issue_rd] != '0;
  assign stall = issue_valid & ~flush & (rawHaz | wawHaz);
  assign issueFire = issue_valid & ~flush & ~stall;
  assign loadPend = issueFire && issue_lat != '0
                 && issue_rd != '0;

  // Walk oldest to youngest so the youngest match is written last.
  always_comb begin
    logic [ADDR_W-1:0] a;
    fwd_sel = '0;
    a = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      a = src_addr[i*ADDR_W +: ADDR_W];
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_valid[k] && a != '0
            && fwd_rd[k*ADDR_W +: ADDR_W] == a)
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
      end
    end
  end

  // A fresh load takes precedence over the running countdown.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (reset || r == 0)
        pend[r] <= '0;
      else if (loadPend && issue_rd == ADDR_W'(r))
        pend[r] <= issue_lat;
      else if (pend[r] != '0)
        pend[r] <= pend[r] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (stall && stall_cycles != '1)
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb_forward_hazard_unit: directed plan scenarios plus random traffic,
// checked against an integer scoreboard model.
module tb_forward_hazard_unit;

  logic       clk;
  logic       reset;
  logic       issue_valid;
  logic [4:0] issue_rd;
  logic [2:0] issue_lat;
  logic [9:0] src_addr;
  logic [1:0] src_used;
  logic       flush;
  logic [1:0] fwd_valid;
  logic [9:0] fwd_rd;
  logic       stall;
  logic [3:0] fwd_sel;
  logic [15:0] stall_cycles;
  logic       stall2;
  logic [3:0] fwdSel2;
  logic [1:0] cyc2;

  int nChk = 0;
  int nErr = 0;
  int pendM [32];
  int cntM = 0;
  int cnt2M = 0;

  forward_hazard_unit dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_lat(issue_lat), .src_addr(src_addr),
    .src_used(src_used), .flush(flush),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .stall(stall), .fwd_sel(fwd_sel),
    .stall_cycles(stall_cycles)
  );

  forward_hazard_unit #(.STALL_CNT_W(2)) dutSmall (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_lat(issue_lat), .src_addr(src_addr),
    .src_used(src_used), .flush(flush),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .stall(stall2), .fwd_sel(fwdSel2),
    .stall_cycles(cyc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, int obs, int exp);
    nChk++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int srcOf(int i);
    return int'(src_addr[i*5 +: 5]);
  endfunction

  function automatic bit modelStall();
    bit haz = 0;
    for (int i = 0; i < 2; i++)
      if (src_used[i] && srcOf(i) != 0 && pendM[srcOf(i)] > 0)
        haz = 1;
    if (issue_valid && issue_rd != 0 && pendM[issue_rd] > 0)
      haz = 1;
    return issue_valid && !flush && haz;
  endfunction

  function automatic int modelSel(int i);
    for (int k = 0; k < 2; k++)
      if (fwd_valid[k] && srcOf(i) != 0
          && int'(fwd_rd[k*5 +: 5]) == srcOf(i))
        return k + 1;
    return 0;
  endfunction

  task automatic settle();
    @(negedge clk);
    chk("stall", int'(stall), int'(modelStall()));
    chk("stall_small", int'(stall2), int'(modelStall()));
    for (int i = 0; i < 2; i++)
      chk($sformatf("fwd_sel%0d", i),
          int'(fwd_sel[i*2 +: 2]), modelSel(i));
    chk("stall_cycles", int'(stall_cycles), cntM);
    chk("stall_cycles_small", int'(cyc2), cnt2M);
  endtask

  task automatic tick();
    bit s;
    s = modelStall();
    @(posedge clk);
    if (reset) begin
      foreach (pendM[r]) pendM[r] = 0;
      cntM = 0;
      cnt2M = 0;
    end else begin
      foreach (pendM[r]) if (pendM[r] > 0) pendM[r]--;
      if (issue_valid && !flush && !s
          && issue_lat != 0 && issue_rd != 0)
        pendM[issue_rd] = int'(issue_lat);
      if (s) begin
        if (cntM < 65535) cntM++;
        if (cnt2M < 3) cnt2M++;
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic clr();
    issue_valid = 0; issue_rd = 0; issue_lat = 0;
    src_addr = 0; src_used = 0; flush = 0;
    fwd_valid = 0; fwd_rd = 0;
  endtask

  task automatic doReset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic countStall(output int n);
    n = 0;
    for (int j = 0; j < 10; j++) begin
      settle();
      if (!stall) return;
      n++;
      tick();
    end
  endtask

  task automatic issue(int rd, int lat);
    issue_valid = 1;
    issue_rd = 5'(rd);
    issue_lat = 3'(lat);
  endtask

  initial begin
    int n;
    int nz;
    foreach (pendM[r]) pendM[r] = 0;
    clr();
    reset = 1;
    tick();
    tick();
    reset = 0;

    settle();
    chk("rst_stall", int'(stall), 0);
    chk("rst_sel", int'(fwd_sel), 0);
    chk("rst_cnt", int'(stall_cycles), 0);
    nz = 0;
    for (int r = 0; r < 32; r++)
      if (dut.pend[r] != 0) nz++;
    chk("rst_pend_nonzero", nz, 0);
    tick();

    fwd_valid = 2'b11;
    fwd_rd = {5'd3, 5'd3};
    src_addr[4:0] = 5'd3;
    settle();
    chk("fwd_youngest", int'(fwd_sel[1:0]), 1);
    tick();
    fwd_valid = 2'b10;
    settle();
    chk("fwd_older", int'(fwd_sel[1:0]), 2);
    tick();
    src_addr[4:0] = 5'd0;
    settle();
    chk("fwd_r0", int'(fwd_sel[1:0]), 0);
    tick();
    clr();

    doReset();
    issue(5, 3);
    cyc();
    issue(6, 0);
    src_addr[4:0] = 5'd5;
    src_used = 2'b01;
    countStall(n);
    chk("raw_len", n, 3);
    chk("raw_cnt", int'(stall_cycles), 3);
    tick();
    clr();

    doReset();
    issue(7, 2);
    cyc();
    issue(7, 1);
    countStall(n);
    chk("waw_len", n, 2);
    tick();
    issue(8, 0);
    src_addr[9:5] = 5'd7;
    settle();
    chk("unused_src", int'(stall), 0);
    tick();
    clr();

    doReset();
    issue(10, 4);
    cyc();
    issue(11, 3);
    src_addr[4:0] = 5'd10;
    src_used = 2'b01;
    flush = 1;
    settle();
    chk("flush_stall", int'(stall), 0);
    tick();
    chk("flush_noload", int'(dut.pend[11]), 0);
    clr();
    issue(4, 1);
    cyc();
    issue(4, 5);
    countStall(n);
    chk("reload_wait", n, 1);
    tick();
    chk("reload_pend", int'(dut.pend[4]), 5);
    clr();

    doReset();
    issue(9, 7);
    cyc();
    issue(0, 0);
    src_addr[4:0] = 5'd9;
    src_used = 2'b01;
    repeat (5) cyc();
    settle();
    chk("sat_small", int'(cyc2), 3);
    chk("cnt_five", int'(stall_cycles), 5);
    tick();
    clr();

    doReset();
    issue(9, 4);
    cyc();
    chk("pend9_loaded", int'(dut.pend[9]), 4);
    clr();
    reset = 1;
    tick();
    reset = 0;
    issue(0, 0);
    src_addr[4:0] = 5'd9;
    src_used = 2'b01;
    settle();
    chk("rst_mid_pend9", int'(dut.pend[9]), 0);
    chk("rst_mid_stall", int'(stall), 0);
    chk("rst_mid_cnt", int'(stall_cycles), 0);
    tick();
    clr();

    for (int j = 0; j < 3000; j++) begin
      reset = ($urandom_range(0, 99) == 0);
      issue_valid = 1'($urandom);
      issue_rd = 5'($urandom_range(0, 7));
      issue_lat = ($urandom_range(0, 1) == 0) ? 3'd0
                : 3'($urandom_range(1, 7));
      src_addr = {5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7))};
      src_used = 2'($urandom);
      flush = ($urandom_range(0, 7) == 0);
      fwd_valid = 2'($urandom);
      fwd_rd = {5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7))};
      cyc();
    end
    reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==",
             nChk, nErr);
    $finish;
  end

endmodule
